// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-serial memory controller.
//   ADDR_W / INSTR_LEN : address and instruction widths
//   LEN_*              : lsb_len encodings (LEN_RSVD behaves as one byte)
//   state_e            : controller FSM states
//   src_e              : which requester owns the current transaction
//   helpers            : length decode, IO-region test, byte get/set
package mem_ctrl_pkg;

  localparam int ADDR_W    = 32;
  localparam int INSTR_LEN = 32;

  localparam logic [1:0] LEN_B1   = 2'd0;
  localparam logic [1:0] LEN_B2   = 2'd1;
  localparam logic [1:0] LEN_RSVD = 2'd2;
  localparam logic [1:0] LEN_B4   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    SRC_IC  = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  // Number of bytes moved for a given lsb_len code.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_B1, LEN_RSVD: n = 3'd1;
      LEN_B2:           n = 3'd2;
      LEN_B4:           n = 3'd4;
      default:          n = 3'd1;
    endcase
    return n;
  endfunction

  // The IO region is identified solely by address bits [17:16].
  function automatic logic in_io_region(input logic [1:0] addr_hi,
                                        input logic [1:0] base_hi);
    return addr_hi == base_hi;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] set_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: single owner of the byte-wide RAM port. Serves 32-bit ICache
// fetches and 1/2/4-byte LSB loads/stores as a sequence of byte accesses.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rdy             global enable; low freezes every register, gates mem_wr
//   jump_wrong      flush; aborts an in-flight ICache fetch
//   ic_req/ic_addr  fetch request            -> ic_done/ic_instr
//   lsb_req/lsb_wr/lsb_addr/lsb_len/lsb_wdata -> lsb_done/lsb_rdata
//   mem_din         RAM read byte (one cycle after mem_a)
//   mem_dout/mem_a/mem_wr  RAM write byte, byte address, write strobe
//   io_buffer_full  IO write buffer full; stalls stores into the IO region
//   dbg_state       current FSM state (state_e encoding)
//
// Handshake: a requester raises req with stable request fields and holds it
// until its done pulses for exactly one cycle (data valid in that cycle). The
// cycle carrying a done pulse never accepts a new request, so the requester
// has that cycle to drop or change req. lsb_req wins over ic_req in IDLE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_instr,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IO_TAG = IO_BASE[17:16];

  state_e                 state_q, state_d;
  src_e                   src_q, src_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [2:0]             nbytes_q, nbytes_d;
  // READ: number of addresses issued so far; WRITE: bytes written so far.
  logic [2:0]             cnt_q, cnt_d;
  // Store data during WRITE, read assembly during READ.
  logic [31:0]            buf_q, buf_d;
  logic [ADDR_W-1:0]      mem_a_q, mem_a_d;
  logic [7:0]             mem_dout_q, mem_dout_d;
  logic                   mem_wr_q, mem_wr_d;
  logic                   ic_done_q, ic_done_d;
  logic                   lsb_done_q, lsb_done_d;
  logic [INSTR_LEN-1:0]   ic_instr_q, ic_instr_d;
  logic [31:0]            lsb_rdata_q, lsb_rdata_d;

  logic [ADDR_W-1:0]      cur_addr;
  logic [1:0]             cap_idx;
  logic [31:0]            asm_word;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    addr_d      = addr_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    ic_instr_d  = ic_instr_q;
    lsb_rdata_d = lsb_rdata_q;

    cur_addr = addr_q + {29'd0, cnt_q};
    // Byte captured at this edge was addressed two enabled edges ago, so
    // its index is cnt-2 (cnt in 2..5 maps to 0..3 modulo 4).
    cap_idx  = cnt_q[1:0] - 2'd2;
    asm_word = set_byte(buf_q, cap_idx, mem_din);

    case (state_q)
      ST_IDLE: begin
        mem_a_d  = '0;
        mem_wr_d = 1'b0;
        if (!ic_done_q && !lsb_done_q) begin
          if (lsb_req) begin
            src_d    = SRC_LSB;
            addr_d   = lsb_addr;
            nbytes_d = len_to_bytes(lsb_len);
            if (lsb_wr) begin
              state_d = ST_WRITE;
              buf_d   = lsb_wdata;
              if (in_io_region(lsb_addr[17:16], IO_TAG) && io_buffer_full) begin
                // Held off: the first byte is issued from WRITE later.
                cnt_d = 3'd0;
              end else begin
                mem_a_d    = lsb_addr;
                mem_dout_d = lsb_wdata[7:0];
                mem_wr_d   = 1'b1;
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = ST_READ;
              buf_d   = '0;  // zero-fill above the loaded length
              mem_a_d = lsb_addr;
              cnt_d   = 3'd1;
            end
          end else if (ic_req && !jump_wrong) begin
            state_d  = ST_READ;
            src_d    = SRC_IC;
            addr_d   = ic_addr;
            nbytes_d = 3'd4;
            buf_d    = '0;
            mem_a_d  = ic_addr;
            cnt_d    = 3'd1;
          end
        end
      end

      ST_READ: begin
        mem_wr_d = 1'b0;
        if (jump_wrong && src_q == SRC_IC) begin
          state_d = ST_IDLE;
          mem_a_d = '0;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < nbytes_q) mem_a_d = cur_addr;
          else                  mem_a_d = '0;
          if (cnt_q >= 3'd2) buf_d = asm_word;
          if (cnt_q == nbytes_q + 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            if (src_q == SRC_IC) begin
              ic_done_d  = 1'b1;
              ic_instr_d = asm_word;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = asm_word;
            end
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q == nbytes_q) begin
          state_d    = ST_IDLE;
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
          cnt_d      = 3'd0;
        end else if (in_io_region(cur_addr[17:16], IO_TAG) && io_buffer_full) begin
          mem_wr_d = 1'b0;
          mem_a_d  = '0;
        end else begin
          mem_a_d    = cur_addr;
          mem_dout_d = get_byte(buf_q, cnt_q[1:0]);
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_a_d  = '0;
        mem_wr_d = 1'b0;
        cnt_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_IC;
      addr_q      <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      ic_instr_q  <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ic_done_q   <= ic_done_d;
      lsb_done_q  <= lsb_done_d;
      ic_instr_q  <= ic_instr_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  // A frozen cycle must not repeat a write into RAM.
  assign mem_wr    = mem_wr_q & rdy;
  assign ic_done   = ic_done_q;
  assign ic_instr  = ic_instr_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A byte-addressed RAM model
// sits on the memory port; a separate reference memory (mdl) holds what the
// RAM must contain, and expected load/fetch data and write traffic are
// derived from it with plain byte arithmetic.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        jump_wrong = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_done;
  logic [31:0] ic_instr;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [1:0]  lsb_len = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic [1:0]  dbg_state;

  int vec_cnt = 0;
  int miscompares = 0;
  bit jw_noise = 1'b0;

  logic [39:0] exp_q[$];   // expected {addr, byte} write traffic
  logic [39:0] wr_log[$];  // observed {addr, byte} write traffic
  logic [7:0]  ram[logic [31:0]];
  logic [7:0]  mdl[logic [31:0]];

  mem_ctrl #(.IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_instr(ic_instr),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM and bus monitor ----------------
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  // The RAM pauses with the rest of the system while rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
    end
  end

  always @(negedge clk) begin
    if (mem_wr) wr_log.push_back({mem_a, mem_dout});
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] mdl_byte(input logic [31:0] a);
    if (mdl.exists(a)) return mdl[a];
    return 8'h00;
  endfunction

  function automatic int n_bytes(input logic [1:0] len);
    if (len == 2'd3) return 4;
    if (len == 2'd1) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = mdl_byte(a + 32'(i));
    return r;
  endfunction

  function automatic void poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    mdl[a] = b;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    rdy = 1'b1;
    tick();
    check("idle_bus", 64'({mem_a, mem_wr, ic_done, lsb_done}), 64'd0);
  endtask

  task automatic ic_op(input logic [31:0] a, input bit stall,
                       output logic [31:0] rd, output int lat);
    ic_req = 1'b1; ic_addr = a; lat = 0; rd = '0;
    for (int i = 0; i < 200; i++) begin
      if (stall) rdy = ($urandom_range(0, 3) != 0);
      tick();
      lat++;
      if (ic_done) begin
        rd = ic_instr;
        break;
      end
    end
    check("ic_handshake", 64'(ic_done), 64'd1);
    rdy = 1'b1; ic_req = 1'b0;
  endtask

  task automatic lsb_op(input bit wr, input logic [31:0] a, input logic [1:0] len,
                        input logic [31:0] wd, input bit stall,
                        output logic [31:0] rd, output int lat);
    lsb_req = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_wdata = wd;
    lat = 0; rd = '0;
    for (int i = 0; i < 200; i++) begin
      if (stall) rdy = ($urandom_range(0, 3) != 0);
      if (jw_noise) jump_wrong = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (lsb_done) begin
        rd = lsb_rdata;
        break;
      end
    end
    check("lsb_handshake", 64'(lsb_done), 64'd1);
    rdy = 1'b1; lsb_req = 1'b0; jump_wrong = 1'b0;
  endtask

  task automatic fetch_chk(input logic [31:0] a, input bit stall, input string tag);
    logic [31:0] rd;
    int lat;
    ic_op(a, stall, rd, lat);
    check(tag, 64'(rd), 64'(mdl_read(a, 4)));
    if (!stall) check({tag, "_lat"}, 64'(lat), 64'd6);
    idle_gap();
  endtask

  task automatic load_chk(input logic [31:0] a, input logic [1:0] len,
                          input bit stall, input string tag);
    logic [31:0] rd;
    int lat;
    lsb_op(1'b0, a, len, $urandom(), stall, rd, lat);
    check(tag, 64'(rd), 64'(mdl_read(a, n_bytes(len))));
    if (!stall) check({tag, "_lat"}, 64'(lat), 64'(n_bytes(len) + 2));
    idle_gap();
  endtask

  task automatic store_chk(input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] wd, input bit stall, input string tag);
    logic [31:0] rd;
    int lat;
    int n;
    n = n_bytes(len);
    exp_q.delete();
    wr_log.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a + 32'(i), wd[8*i +: 8]});
      mdl[a + 32'(i)] = wd[8*i +: 8];
    end
    lsb_op(1'b1, a, len, wd, stall, rd, lat);
    if (!stall) check({tag, "_lat"}, 64'(lat), 64'(n + 1));
    check({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0)
      check({tag, "_wr"}, 64'(wr_log.pop_front()), 64'(exp_q.pop_front()));
    idle_gap();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          stall;
    int          kind;
    int          cnt;
    logic [31:0] a;
    logic [1:0]  len;
    logic        seen;

    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_bus", 64'({mem_a, mem_dout, mem_wr, ic_done, lsb_done}), 64'd0);
    check("rst_data", {ic_instr, lsb_rdata}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;

    for (int i = 0; i < 256; i++) poke(32'h1000 + 32'(i), 8'($urandom()));
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05);
    poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    poke(32'h1004, 8'h93); poke(32'h1005, 8'h05);
    poke(32'h1006, 8'h10); poke(32'h1007, 8'h00);
    tick();

    // fetch 0x1000 with cycle-exact address sequence
    ic_req = 1'b1; ic_addr = 32'h1000;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) check($sformatf("fetch_mem_a%0d", c), 64'(mem_a), 64'(32'h1000 + 32'(c - 1)));
      if (c == 5) check("fetch_early_done", 64'(ic_done), 64'd0);
    end
    check("fetch_done", 64'(ic_done), 64'd1);
    check("fetch_instr", 64'(ic_instr), 64'h0000_0513);
    ic_req = 1'b0;
    tick();
    check("fetch_pulse", 64'(ic_done), 64'd0);

    // 4-byte store
    store_chk(32'h2000, 2'd3, 32'hDEAD_BEEF, 1'b0, "st_deadbeef");

    // concurrent requests: LSB first, fetch after the bubble
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h2001; lsb_len = 2'd0;
    ic_req = 1'b1; ic_addr = 32'h1000;
    cnt = 0;
    for (int i = 0; i < 50 && !lsb_done; i++) begin tick(); cnt++; end
    check("conc_lsb_lat", 64'(cnt), 64'd3);
    check("conc_lsb_data", 64'(lsb_rdata), 64'h0000_00BE);
    check("conc_ic_wait", 64'(ic_done), 64'd0);
    lsb_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && !ic_done; i++) begin tick(); cnt++; end
    check("conc_ic_lat", 64'(cnt), 64'd7);
    check("conc_ic_data", 64'(ic_instr), 64'h0000_0513);
    ic_req = 1'b0;
    idle_gap();

    // jump_wrong abort after edge 3, then a flushed request in IDLE
    ic_req = 1'b1; ic_addr = 32'h1000;
    tick(); tick(); tick();
    jump_wrong = 1'b1; ic_req = 1'b0;
    tick();
    check("jw_abort_state", 64'(dbg_state), 64'(ST_IDLE));
    ic_req = 1'b1;
    tick();
    check("jw_idle_reject", 64'({dbg_state, mem_a}), 64'({ST_IDLE, 32'h0}));
    jump_wrong = 1'b0; ic_req = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= ic_done; end
    check("jw_no_done", 64'(seen), 64'd0);
    fetch_chk(32'h1004, 1'b0, "jw_refetch");
    check("jw_refetch_val", 64'(ic_instr), 64'h0010_0593);

    // IO store held by io_buffer_full
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 2'd0; lsb_wdata = 32'h5A;
    mdl[32'h30000] = 8'h5A;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("io_hold%0d", c), 64'({mem_wr, lsb_done}), 64'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_issue", 64'({mem_wr, mem_a, mem_dout}), 64'({1'b1, 32'h30000, 8'h5A}));
    tick();
    check("io_done", 64'({lsb_done, mem_wr}), 64'd2);
    lsb_req = 1'b0;
    idle_gap();
    load_chk(32'h30000, 2'd0, 1'b0, "io_load");

    // rdy freeze in the middle of a store
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h1300; lsb_len = 2'd0; lsb_wdata = 32'h77;
    mdl[32'h1300] = 8'h77;
    tick();
    check("rdy_pre", 64'({mem_wr, mem_a}), 64'({1'b1, 32'h1300}));
    rdy = 1'b0;
    #1;
    check("rdy_gate", 64'(mem_wr), 64'd0);
    tick(); tick(); tick();
    check("rdy_hold", 64'({lsb_done, mem_a, mem_dout}), 64'({1'b0, 32'h1300, 8'h77}));
    rdy = 1'b1;
    #1;
    check("rdy_resume", 64'(mem_wr), 64'd1);
    tick();
    check("rdy_done", 64'({lsb_done, mem_wr}), 64'd2);
    lsb_req = 1'b0;
    idle_gap();
    load_chk(32'h1300, 2'd0, 1'b0, "rdy_load");

    // address wrap-around and the reserved length code
    store_chk(32'hFFFF_FFFE, 2'd3, 32'hA1B2_C3D4, 1'b0, "wrap_st");
    load_chk(32'hFFFF_FFFE, 2'd3, 1'b0, "wrap_ld");
    fetch_chk(32'hFFFF_FFFF, 1'b0, "wrap_fetch");
    store_chk(32'h1400, 2'd2, 32'h1122_3344, 1'b0, "len2_st");
    load_chk(32'h1400, 2'd3, 1'b0, "len2_ld");

    // randomized traffic; the tail runs with random rdy stalls
    jw_noise = 1'b1;
    for (int i = 0; i < 160; i++) begin
      stall = (i >= 110);
      kind  = $urandom_range(0, 2);
      a     = 32'h1000 + 32'($urandom_range(0, 255));
      len   = 2'($urandom_range(0, 3));
      case (kind)
        0:       fetch_chk(a, stall, "rnd_fetch");
        1:       load_chk(a, len, stall, "rnd_load");
        default: store_chk(a, len, $urandom(), stall, "rnd_store");
      endcase
    end
    jw_noise = 1'b0;

    // asynchronous reset in the middle of a 4-byte store
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h2100; lsb_len = 2'd3; lsb_wdata = 32'h1122_3344;
    tick(); tick();
    check("rstmid_pre", 64'(mem_wr), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_bus", 64'({mem_a, mem_dout, mem_wr, ic_done, lsb_done}), 64'd0);
    check("rstmid_data", {ic_instr, lsb_rdata}, 64'd0);
    check("rstmid_state", 64'(dbg_state), 64'(ST_IDLE));
    lsb_req = 1'b0;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= lsb_done | ic_done | mem_wr; end
    check("rstmid_quiet", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the ICache fetch interface, and the single owner of the byte-wide RAM port.
- Serves 32-bit instruction fetches from ICache and 1/2/4-byte loads and stores from the LSB.
- Serializes every access into byte transactions on mem_a/mem_din/mem_dout/mem_wr.
- Sits between ICache/LSB and the top-level RAM/IO bus.

Parameters:
- IO_BASE, 32'h30000, start of the IO region (an address is IO when addr[17:16]==2'b11).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- jump_wrong  in  1  branch mispredict flush; aborts an in-flight ICache fetch
- ic_req  in  1  ICache fetch request, level-held until ic_done
- ic_addr  in  32  fetch address
- ic_done  out  1  one-cycle pulse; ic_instr is valid this cycle
- ic_instr  out  32  fetched word, little-endian
- lsb_req  in  1  LSB request, level-held until lsb_done
- lsb_wr  in  1  1 = store, 0 = load
- lsb_addr  in  32  access address
- lsb_len  in  2  0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes (2 is illegal)
- lsb_wdata  in  32  store data, low bytes used
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-filled above len (LSB performs sign extension)
- mem_din  in  8  RAM read byte, valid one cycle after mem_a is presented
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; mem_a=0; mem_dout=0; mem_wr=0; ic_done=0; lsb_done=0; ic_instr=0; lsb_rdata=0; byte counter=0.
- All outputs are registered. States are IDLE, READ, WRITE.
- IDLE arbitration: lsb_req has priority over ic_req. The winner's address, length (ICache is always 4) and source are latched on the accepting edge.
- No request is accepted in a cycle where ic_done or lsb_done is high (one bubble cycle). The requester sees done and drops or changes its request.
- READ timing, N bytes, request sampled at edge 1:
  - Edge k (1..N): mem_a<=addr+k-1.
  - Edge k+2: capture mem_din into byte k-1.
  - Edge N+2: last capture; done<=1 and data valid in the following cycle; state->IDLE.
  - A 4-byte fetch therefore shows ic_done in the cycle after edge 6.
- WRITE timing:
  - Edge k (1..N): mem_a<=addr+k-1, mem_dout<=byte k-1, mem_wr<=1.
  - Edge N+1: mem_wr<=0, mem_a<=0, lsb_done<=1.
- IO stores: if the address is in the IO region and io_buffer_full=1, the byte is not issued. mem_wr stays 0 and the controller waits in WRITE until io_buffer_full=0.
- IO loads follow normal READ timing.
- Idle cycles: mem_wr=0, mem_a=0.
- jump_wrong=1 at an edge:
  - In-flight ICache fetch is aborted; state->IDLE; ic_done stays 0; partial data is discarded.
  - An ic_req in IDLE at that edge is not accepted.
  - LSB transactions are unaffected; an accepted store always completes.
- rdy=0: no register updates; mem_wr output gated to 0. The transaction resumes byte-exact when rdy returns.
- Address arithmetic is 32-bit wrap-around, with no alignment requirement.
- lsb_len=2 is treated as 1 byte.
- Concurrent requests: ic_req waits while an LSB access runs, and is accepted after the bubble cycle.

Decomposition:
- Shared define file holds:
  - `ADDR and `INSTRLEN width macros
  - IO-region check macro
  - lsb_len encodings
  - state encodings
- Single module. The byte counter and shift assembly are inline; no sub-module is natural.

Test Plan:
- RAM preloaded 0x1000..0x1003 = 13,05,00,00; ic_req with ic_addr=0x1000 -> mem_a sequence 1000,1001,1002,1003; ic_done in the cycle after edge 6; ic_instr=0x00000513.
- lsb store, len=3, addr=0x2000, wdata=0xDEADBEEF -> mem_wr high 4 cycles with bytes EF,BE,AD,DE at 2000..2003; then lsb_done; mem_wr=0.
- lsb_req (load, len=0, 0x2001) and ic_req raised in the same cycle -> LSB served first; lsb_rdata=0x000000BE; ic fetch starts after the bubble cycle.
- ic fetch in progress with jump_wrong pulsed after edge 3 -> no ic_done; state IDLE; next ic_req with addr 0x1004 is served cleanly.
- lsb store, len=0, addr=0x30000, io_buffer_full=1 for 5 cycles -> mem_wr=0 throughout; byte written on the first cycle after release; lsb_done follows.
- rst asserted mid 4-byte store -> mem_wr=0 immediately (asynchronous); all outputs at reset values; no done pulse.
